// File: rtl/rr_mux4x1.sv
// Four-channel round-robin stream merger with a single registered output slot.
// Words are passed through unchanged and tagged with the index of the channel they came from.
module rr_mux4x1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic             v0,
    input  logic             v1,
    input  logic             v2,
    input  logic             v3,
    output logic             r0,
    output logic             r1,
    output logic             r2,
    output logic             r3,
    output logic [WIDTH-1:0] y,
    output logic             yv,
    input  logic             yr,
    output logic [1:0]       ysel
);

    // Handshake: a word moves on any port in a cycle where its valid and ready
    // are both high at the rising edge; a source holds valid/data until then.

    logic [3:0]       v_vec;
    logic [3:0]       grant;
    logic [1:0]       gidx;
    logic [1:0]       idx;
    logic             any_valid;
    logic             load;
    logic [1:0]       ptr;
    logic [WIDTH-1:0] sel_d;

    assign v_vec = {v3, v2, v1, v0};
    assign load  = ~yv | yr;

    // Scan from ptr upward; the first valid channel wins.
    always_comb begin
        any_valid = 1'b0;
        gidx      = ptr;
        idx       = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!any_valid && v_vec[idx]) begin
                any_valid = 1'b1;
                gidx      = idx;
            end
        end
    end

    always_comb begin
        grant = 4'b0000;
        if (load && any_valid && !rst)
            grant[gidx] = 1'b1;
    end

    assign r0 = grant[0];
    assign r1 = grant[1];
    assign r2 = grant[2];
    assign r3 = grant[3];

    always_comb begin
        sel_d = d0;
        case (gidx)
            2'd0: sel_d = d0;
            2'd1: sel_d = d1;
            2'd2: sel_d = d2;
            2'd3: sel_d = d3;
            default: sel_d = d0;
        endcase
    end

    // yv clears only when the slot drains with nothing new arriving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y    <= '0;
            ysel <= 2'd0;
            yv   <= 1'b0;
            ptr  <= 2'd0;
        end else if (load) begin
            if (any_valid) begin
                y    <= sel_d;
                ysel <= gidx;
                yv   <= 1'b1;
                ptr  <= gidx + 2'd1;
            end else begin
                yv   <= 1'b0;
            end
        end
    end

endmodule
